// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//
// Fetch/decode/execute sequencer for the LEG4 (4004-style) core.
// Assembles 1- and 2-byte instructions from the ROM byte stream. It drives
// the external ALU from the captured instruction and owns the architectural
// ACC, CY and Z registers, which take the ALU result at writeback. Each
// decoded instruction is offered downstream through a valid/ready handshake.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   instr_valid    instruction byte valid
//   instr_data     instruction byte, [7:4]=OPR, [3:0]=OPA
//   instr_ready    sequencer accepts a byte this cycle
//   reg_sel        register file read index (captured OPA)
//   reg_data       register file read data (combinational)
//   alu_op         ALU operation code (0 = NOP)
//   alu_acc        ACC to the ALU
//   alu_opa        ALU operand
//   alu_carry      CY to the ALU
//   alu_result     ALU result
//   alu_carry_out  ALU carry/borrow
//   alu_zero       ALU zero flag
//   exec_valid     decoded instruction available
//   exec_ready     downstream accepts the instruction
//   exec_opr       captured OPR
//   exec_opa       captured OPA
//   exec_op2       second byte (0 for 1-byte instructions)
//   acc_out        architectural ACC
//   cy_out         architectural CY
//   z_out          zero flag from the last ALU writeback
// ---------------------------------------------------------------------------
module inst_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic [3:0] reg_sel,
  input  logic [3:0] reg_data,
  output logic [3:0] alu_op,
  output logic [3:0] alu_acc,
  output logic [3:0] alu_opa,
  output logic       alu_carry,
  input  logic [3:0] alu_result,
  input  logic       alu_carry_out,
  input  logic       alu_zero,
  output logic       exec_valid,
  input  logic       exec_ready,
  output logic [3:0] exec_opr,
  output logic [3:0] exec_opa,
  output logic [7:0] exec_op2,
  output logic [3:0] acc_out,
  output logic       cy_out,
  output logic       z_out
);

  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;  // FIM when OPA[0]=0, SRC otherwise
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_ADD = 4'h8;
  localparam logic [3:0] OPR_SUB = 4'h9;
  localparam logic [3:0] OPR_LDM = 4'hD;
  localparam logic [3:0] ALU_NOP = 4'h0;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic [7:0] op2_q, op2_d;
  logic [3:0] acc_q, acc_d;
  logic       cy_q, cy_d;
  logic       z_q, z_d;

  logic byte_xfer;
  logic exec_xfer;
  logic two_byte;

  // Decode length from the incoming first byte.
  always_comb begin
    two_byte = 1'b0;
    case (instr_data[7:4])
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two_byte = 1'b1;
      OPR_FIM:                            two_byte = ~instr_data[0];
      default:                            two_byte = 1'b0;
    endcase
  end

  // Both handshakes are masked by rst so nothing moves in a reset cycle.
  assign instr_ready = (state_q != EXEC) && !rst;
  assign exec_valid  = (state_q == EXEC) && !rst;
  assign byte_xfer   = instr_valid && instr_ready;
  assign exec_xfer   = exec_valid && exec_ready;

  // Next-state and writeback.
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    z_d     = z_q;
    case (state_q)
      FETCH1: begin
        if (byte_xfer) begin
          opr_d   = instr_data[7:4];
          opa_d   = instr_data[3:0];
          op2_d   = 8'h00;
          state_d = two_byte ? FETCH2 : EXEC;
        end
      end
      FETCH2: begin
        if (byte_xfer) begin
          op2_d   = instr_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_xfer) begin
          state_d = FETCH1;
          case (opr_q)
            OPR_ADD, OPR_SUB: begin
              acc_d = alu_result;
              cy_d  = alu_carry_out;
              z_d   = alu_zero;
            end
            OPR_LDM: begin
              acc_d = alu_result;
              z_d   = alu_zero;
            end
            default: ;
          endcase
        end
      end
      default: state_d = FETCH1;
    endcase
  end

  // ALU drive comes purely from the captured instruction so it is stable
  // for as long as EXEC is held.
  always_comb begin
    alu_op  = ALU_NOP;
    alu_opa = 4'h0;
    case (opr_q)
      OPR_ADD, OPR_SUB: begin
        alu_op  = opr_q;
        alu_opa = reg_data;
      end
      OPR_LDM: begin
        alu_op  = OPR_LDM;
        alu_opa = opa_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH1;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      op2_q   <= 8'h00;
      acc_q   <= 4'h0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
    end
  end

  assign reg_sel   = opa_q;
  assign alu_acc   = acc_q;
  assign alu_carry = cy_q;
  assign exec_opr  = opr_q;
  assign exec_opa  = opa_q;
  assign exec_op2  = op2_q;
  assign acc_out   = acc_q;
  assign cy_out    = cy_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inst_sequencer
//
// Directed bench for inst_sequencer. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. An ALU and a small
// register file surround the DUT. Each issued instruction pushes its
// expected execute fields and resulting ACC/CY/Z into a queue; a monitor
// thread pops on every execute handshake and checks the architectural
// registers one cycle later.
// ---------------------------------------------------------------------------
module tb_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [3:0] reg_sel;
  logic [3:0] reg_data;
  logic [3:0] alu_op;
  logic [3:0] alu_acc;
  logic [3:0] alu_opa;
  logic       alu_carry;
  logic [3:0] alu_result;
  logic       alu_carry_out;
  logic       alu_zero;
  logic       exec_valid;
  logic       exec_ready;
  logic [3:0] exec_opr;
  logic [3:0] exec_opa;
  logic [7:0] exec_op2;
  logic [3:0] acc_out;
  logic       cy_out;
  logic       z_out;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_ready   (instr_ready),
    .reg_sel       (reg_sel),
    .reg_data      (reg_data),
    .alu_op        (alu_op),
    .alu_acc       (alu_acc),
    .alu_opa       (alu_opa),
    .alu_carry     (alu_carry),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero),
    .exec_valid    (exec_valid),
    .exec_ready    (exec_ready),
    .exec_opr      (exec_opr),
    .exec_opa      (exec_opa),
    .exec_op2      (exec_op2),
    .acc_out       (acc_out),
    .cy_out        (cy_out),
    .z_out         (z_out)
  );

  // Register file: r0=0, r1=6, r2=3, r3=1.
  logic [3:0] regs [16];
  assign reg_data = regs[reg_sel];

  // External ALU: ADD = acc+opa+cy, SUB = acc-opa-cy (bit 4 = carry/borrow).
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = 5'd0;
    case (alu_op)
      4'h8:    alu_sum = {1'b0, alu_acc} + {1'b0, alu_opa} + {4'b0, alu_carry};
      4'h9:    alu_sum = {1'b0, alu_acc} - {1'b0, alu_opa} - {4'b0, alu_carry};
      4'hD:    alu_sum = {1'b0, alu_opa};
      default: alu_sum = {1'b0, alu_acc};
    endcase
  end
  assign alu_result    = alu_sum[3:0];
  assign alu_carry_out = alu_sum[4];
  assign alu_zero      = (alu_sum[3:0] == 4'h0);

  typedef struct {
    logic [3:0] opr;
    logic [3:0] opa;
    logic [7:0] op2;
    logic [3:0] aop;
    logic [3:0] aopa;
    logic [3:0] acc;
    logic       cy;
    logic       z;
  } exp_t;

  exp_t sb_q[$];
  exp_t arch_exp;
  bit   arch_pending = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] opr, input logic [3:0] opa, input logic [7:0] op2,
                      input logic [3:0] aop, input logic [3:0] aopa,
                      input logic [3:0] acc, input logic cy, input logic z);
    exp_t e;
    e.opr = opr; e.opa = opa; e.op2 = op2; e.aop = aop; e.aopa = aopa;
    e.acc = acc; e.cy = cy; e.z = z;
    sb_q.push_back(e);
  endtask

  // Present one byte until it transfers; returns 1 ns after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit ok = 1'b0;
    instr_valid = 1'b1;
    instr_data  = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (instr_ready) ok = 1'b1;
      step();
      n++;
    end
    instr_valid = 1'b0;
    instr_data  = 8'hFF;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, required acceptance within 100 cycles", b);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || arch_pending) && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (sb_q.size() != 0 || arch_pending) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d transactions outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 4'h0;
    regs[1] = 4'h6;
    regs[2] = 4'h3;
    regs[3] = 4'h1;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    exec_ready  = 1'b1;

    // Monitor thread: pop and compare on each execute handshake.
    fork
      forever begin
        @(negedge clk);
        if (arch_pending) begin
          chk("wb_acc", {4'h0, acc_out}, {4'h0, arch_exp.acc});
          chk("wb_cy",  {7'h0, cy_out},  {7'h0, arch_exp.cy});
          chk("wb_z",   {7'h0, z_out},   {7'h0, arch_exp.z});
          arch_pending = 1'b0;
        end
        if (exec_valid && exec_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_exec: opr=%0h opa=%0h, required no transfer", exec_opr, exec_opa);
          end else begin
            arch_exp = sb_q.pop_front();
            $display("exec opr=%0h opa=%0h op2=%02h alu_op=%0h alu_opa=%0h",
                     exec_opr, exec_opa, exec_op2, alu_op, alu_opa);
            chk("exec_opr", {4'h0, exec_opr}, {4'h0, arch_exp.opr});
            chk("exec_opa", {4'h0, exec_opa}, {4'h0, arch_exp.opa});
            chk("exec_op2", exec_op2,         arch_exp.op2);
            chk("alu_op",   {4'h0, alu_op},   {4'h0, arch_exp.aop});
            chk("alu_opa",  {4'h0, alu_opa},  {4'h0, arch_exp.aopa});
            arch_pending = 1'b1;
          end
        end
      end
    join_none

    // Reset state.
    step();
    step();
    @(negedge clk);
    chk("rst_instr_ready", {7'h0, instr_ready}, 8'h00);
    chk("rst_exec_valid",  {7'h0, exec_valid},  8'h00);
    chk("rst_acc",         {4'h0, acc_out},     8'h00);
    chk("rst_cy",          {7'h0, cy_out},      8'h00);
    chk("rst_z",           {7'h0, z_out},       8'h00);
    chk("rst_alu_op",      {4'h0, alu_op},      8'h00);
    chk("rst_reg_sel",     {4'h0, reg_sel},     8'h00);
    chk("rst_exec_op2",    exec_op2,            8'h00);
    step();
    rst = 1'b0;

    // LDM 5: exec_valid one cycle after the transfer; ACC=5, CY=0, Z=0.
    push(4'hD, 4'h5, 8'h00, 4'hD, 4'h5, 4'h5, 1'b0, 1'b0);
    send_byte(8'hD5);
    @(negedge clk);
    chk("ldm_exec_valid_latency", {7'h0, exec_valid}, 8'h01);
    step();

    // LDM F, then ADD r3 (=1): F+1+0 -> ACC=0, CY=1, Z=1.
    push(4'hD, 4'hF, 8'h00, 4'hD, 4'hF, 4'hF, 1'b0, 1'b0);
    send_byte(8'hDF);
    push(4'h8, 4'h3, 8'h00, 4'h8, 4'h1, 4'h0, 1'b1, 1'b1);
    send_byte(8'h83);
    @(negedge clk);
    chk("add_reg_sel", {4'h0, reg_sel}, 8'h03);
    step();
    drain();

    // Reset clears CY; LDM 2 then SUB r2 (=3): 2-3-0 -> ACC=F, CY=1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(4'hD, 4'h2, 8'h00, 4'hD, 4'h2, 4'h2, 1'b0, 1'b0);
    send_byte(8'hD2);
    push(4'h9, 4'h2, 8'h00, 4'h9, 4'h3, 4'hF, 1'b1, 1'b0);
    send_byte(8'h92);
    drain();

    // JUN 4A 37 with a 2-cycle gap; ACC/CY unchanged.
    push(4'h4, 4'hA, 8'h37, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    send_byte(8'h4A);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("jun_gap_ready", {7'h0, instr_ready}, 8'h01);
      chk("jun_gap_valid", {7'h0, exec_valid},  8'h00);
      step();
    end
    send_byte(8'h37);
    drain();

    // FIM takes a second byte.
    push(4'h2, 4'h0, 8'h55, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    send_byte(8'h20);
    @(negedge clk);
    chk("fim_after_byte1_valid", {7'h0, exec_valid}, 8'h00);
    step();
    send_byte(8'h55);
    drain();

    // SRC is single byte: EXEC immediately, op2=0.
    push(4'h2, 4'h1, 8'h00, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    send_byte(8'h21);
    @(negedge clk);
    chk("src_exec_valid", {7'h0, exec_valid}, 8'h01);
    step();
    drain();

    // ADD r1 (=6): F+6+1 = 0x16 -> ACC=6, CY=1, Z=0.
    push(4'h8, 4'h1, 8'h00, 4'h8, 4'h6, 4'h6, 1'b1, 1'b0);
    send_byte(8'h81);
    drain();

    // SUB r1 held in EXEC for 4 cycles, then reset discards it.
    exec_ready = 1'b0;
    send_byte(8'h91);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_exec_valid", {7'h0, exec_valid}, 8'h01);
      chk("hold_exec_opr",   {4'h0, exec_opr},   8'h09);
      chk("hold_exec_opa",   {4'h0, exec_opa},   8'h01);
      chk("hold_exec_op2",   exec_op2,           8'h00);
      chk("hold_alu_op",     {4'h0, alu_op},     8'h09);
      chk("hold_alu_opa",    {4'h0, alu_opa},    8'h06);
      chk("hold_acc",        {4'h0, acc_out},    8'h06);
      chk("hold_instr_ready",{7'h0, instr_ready},8'h00);
      step();
    end
    rst = 1'b1;
    exec_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_instr_ready", {7'h0, instr_ready}, 8'h01);
    chk("post_rst_exec_valid",  {7'h0, exec_valid},  8'h00);
    chk("post_rst_acc",         {4'h0, acc_out},     8'h00);
    chk("post_rst_cy",          {7'h0, cy_out},      8'h00);
    chk("post_rst_z",           {7'h0, z_out},       8'h00);
    chk("post_rst_exec_opr",    {4'h0, exec_opr},    8'h00);
    step();

    // Normal operation resumes after reset.
    push(4'hD, 4'h7, 8'h00, 4'hD, 4'h7, 4'h7, 1'b0, 1'b0);
    send_byte(8'hD7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Fetch/decode/execute sequencer for the LEG4 (4004-style) core. It accepts instruction bytes from the ROM fetch path and assembles 1- and 2-byte instructions. It drives the ALU operand and control inputs, and writes the ALU result and carry back into the ACC and CY registers it owns. Each decoded instruction is presented to downstream units (register file, PC/branch logic) through a valid/ready handshake.

## Interface
Parameters:
- none; widths are fixed by the 4-bit datapath and 8-bit instruction byte.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr_data holds a valid instruction byte.
- instr_data  in  8  instruction byte; [7:4]=OPR, [3:0]=OPA.
- instr_ready  out  1  sequencer accepts a byte this cycle.
- reg_sel  out  4  register index for the read (= captured OPA).
- reg_data  in  4  register file read data for reg_sel, combinational.
- alu_op  out  4  ALU operation code.
- alu_acc  out  4  ACC value to the ALU.
- alu_opa  out  4  ALU operand.
- alu_carry  out  1  CY value to the ALU.
- alu_result  in  4  ALU result.
- alu_carry_out  in  1  ALU carry/borrow.
- alu_zero  in  1  ALU zero flag.
- exec_valid  out  1  decoded instruction available.
- exec_ready  in  1  downstream accepts the instruction.
- exec_opr  out  4  captured OPR.
- exec_opa  out  4  captured OPA.
- exec_op2  out  8  second byte for 2-byte instructions; 0 for 1-byte instructions.
- acc_out  out  4  architectural ACC.
- cy_out  out  1  architectural CY.
- z_out  out  1  zero flag from the last ALU writeback.

## Operation
- States: FETCH1, FETCH2, EXEC. Reset enters FETCH1.
- instr_ready is 1 in FETCH1 and FETCH2 and 0 in EXEC. It is forced to 0 while rst=1.
- A byte transfers when instr_valid=1 and instr_ready=1.
- FETCH1, on transfer:
  - Capture OPR/OPA and clear op2.
  - Go to FETCH2 if the instruction is 2-byte, otherwise go to EXEC.
  - 2-byte instructions: OPR=1 (JCN), 4 (JUN), 5 (JMS), 7 (ISZ), and OPR=2 with OPA[0]=0 (FIM).
  - OPR=2 with OPA[0]=1 (SRC) and OPR=3 (FIN/JIN) are 1-byte.
- FETCH2, on transfer: capture the byte into op2 and go to EXEC.
- No transfer in FETCH1 or FETCH2: hold state.
- EXEC:
  - exec_valid=1 for the whole state.
  - On exec_valid and exec_ready: perform the writeback and return to FETCH1.
  - Without exec_ready: hold state. All exec_* and alu_* outputs stay stable.
- ALU drive (combinational from the captured instruction):
  - OPR=8 (ADD) or 9 (SUB): alu_op=OPR, alu_opa=reg_data.
  - OPR=D (LDM): alu_op=D, alu_opa=OPA.
  - Any other OPR: alu_op=0 (NOP), alu_opa=0.
  - alu_acc=ACC and alu_carry=CY at all times.
- Writeback, on the EXEC transfer only:
  - ADD and SUB: ACC←alu_result, CY←alu_carry_out, Z←alu_zero.
  - LDM: ACC←alu_result and Z←alu_zero. CY is unchanged.
  - Other OPR values: ACC, CY and Z are unchanged.
- Arithmetic is performed by the ALU. ADD uses a 5-bit sum, with CY set on overflow past 15. SUB computes ACC−opa−CY in 5 bits, and CY is set on borrow.

## Timing
- Reset values:
  - State FETCH1.
  - ACC=0, CY=0, Z=0.
  - Captured OPR, OPA and op2 = 0.
  - exec_valid=0, instr_ready=0 while in reset.
  - alu_op=0, reg_sel=0.
- A 1-byte instruction takes at least 2 cycles: the fetch transfer, then EXEC.
- A 2-byte instruction takes at least 3 cycles.
- exec_valid rises in the cycle after the final byte transfer.
- acc_out, cy_out and z_out are updated in the cycle after the EXEC transfer.
- exec_ready may be tied high. Throughput is then one instruction per 2 or 3 cycles.
- A gap in instr_valid between the two bytes of a 2-byte instruction leaves the state in FETCH2 and keeps the first byte.
- rst during FETCH2 or EXEC returns the state to FETCH1 and clears ACC, CY and Z. The partial instruction is discarded and no writeback occurs.
- instr_data is ignored whenever instr_ready=0.

## Test plan
- Reset, then LDM 5 (0xD5) with exec_ready=1:
  - exec_valid is seen 1 cycle after the transfer.
  - Afterwards ACC=5, CY=0, Z=0.
- ACC=0xF, CY=0, reg_data=1, ADD (0x83):
  - reg_sel=3.
  - Afterwards ACC=0, CY=1, Z=1.
- ACC=2, CY=0, reg_data=3, SUB (0x92):
  - Afterwards ACC=0xF, CY=1.
- JUN 0x4A then 0x37, with a 2-cycle instr_valid gap between bytes:
  - exec_opr=4, exec_opa=A, exec_op2=0x37.
  - ACC and CY unchanged.
- FIM 0x20 is followed by a second byte; SRC 0x21 is not:
  - FIM has exec_op2 equal to the second byte.
  - SRC has exec_op2=0 and goes directly to EXEC.
- Hold exec_ready=0 for 4 cycles in EXEC, then assert rst:
  - Outputs are stable while held.
  - After the rst cycle: state FETCH1, ACC=0, CY=0, no writeback.
